// File: rtl/config_loader_pkg.sv
// -----------------------------------------------------------------------------
// config_loader_pkg
//   Shared definitions for the configuration-chain loader.
//   - state_t : FSM state encoding (IDLE, LOAD, SHIFT, DONE)
//   - cnt_w() : width of a counter that must hold 0..chain_len inclusive
// -----------------------------------------------------------------------------
package config_loader_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        SHIFT = 2'd2,
        DONE  = 2'd3
    } state_t;

    // Counter width able to represent chain_len itself, since the bit counter
    // steps one past the last bit index on the final shift.
    function automatic int cnt_w(input int chain_len);
        return $clog2(chain_len + 1);
    endfunction

    localparam int DEFAULT_CHAIN_LEN = 8;
    localparam int DEFAULT_CNT_W     = cnt_w(DEFAULT_CHAIN_LEN);

endpackage

// File: rtl/config_loader.sv
// -----------------------------------------------------------------------------
// config_loader
//   Accepts bitstream words from a host and shifts them LSB-first into a
//   serial configuration chain of CHAIN_LEN bits.
//
// Parameters
//   WORD_W    : width of one host word
//   CHAIN_LEN : total number of config bits in the downstream chain
//
// Ports
//   config_clk   in  : clock, rising edge
//   config_reset in  : asynchronous active-high reset
//   start        in  : one-cycle request to begin a load (honoured only in IDLE)
//   abort        in  : synchronous cancel, highest priority
//   word_in      in  : next bitstream word
//   word_valid   in  : word_in is valid
//   word_ready   out : loader accepts word_in this cycle
//   cfg_sout     out : serial data to the chain's config_in
//   cfg_shift_en out : chain shifts this cycle
//   busy         out : load in progress (LOAD or SHIFT)
//   done         out : one-cycle pulse on load completion
// -----------------------------------------------------------------------------
module config_loader
    import config_loader_pkg::*;
#(
    parameter int WORD_W    = 32,
    parameter int CHAIN_LEN = 8
) (
    input  logic              config_clk,
    input  logic              config_reset,
    input  logic              start,
    input  logic              abort,
    input  logic [WORD_W-1:0] word_in,
    input  logic              word_valid,
    output logic              word_ready,
    output logic              cfg_sout,
    output logic              cfg_shift_en,
    output logic              busy,
    output logic              done
);

    localparam int CNT_W = cnt_w(CHAIN_LEN);
    localparam int WB_W  = (WORD_W > 1) ? $clog2(WORD_W) : 1;

    localparam logic [CNT_W-1:0] LAST_BIT  = CNT_W'(CHAIN_LEN - 1);
    localparam logic [WB_W-1:0]  LAST_WBIT = WB_W'(WORD_W - 1);

    state_t            state, state_nx;
    logic [WORD_W-1:0] shreg, shreg_nx;
    logic [CNT_W-1:0]  bit_cnt, bit_cnt_nx;   // global stream bit index
    logic [WB_W-1:0]   wbit_cnt, wbit_cnt_nx; // bit index inside current word

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge value of its inputs regardless of statement order.
    always_ff @(posedge config_clk or posedge config_reset) begin
        if (config_reset) begin
            state    <= IDLE;
            shreg    <= '0;
            bit_cnt  <= '0;
            wbit_cnt <= '0;
        end else begin
            state    <= state_nx;
            shreg    <= shreg_nx;
            bit_cnt  <= bit_cnt_nx;
            wbit_cnt <= wbit_cnt_nx;
        end
    end

    // NOTE: every signal written here gets a default first, so no path through
    // the case statement can leave one unassigned and infer a latch.
    always_comb begin
        state_nx     = state;
        shreg_nx     = shreg;
        bit_cnt_nx   = bit_cnt;
        wbit_cnt_nx  = wbit_cnt;
        word_ready   = 1'b0;
        cfg_sout     = 1'b0;
        cfg_shift_en = 1'b0;
        busy         = 1'b0;
        done         = 1'b0;

        unique case (state)
            IDLE: begin
                bit_cnt_nx  = '0;
                wbit_cnt_nx = '0;
                if (start) begin
                    state_nx = LOAD;
                end
            end

            LOAD: begin
                word_ready = 1'b1;
                busy       = 1'b1;
                if (word_valid) begin
                    shreg_nx    = word_in;
                    wbit_cnt_nx = '0;
                    state_nx    = SHIFT;
                end
            end

            SHIFT: begin
                busy         = 1'b1;
                cfg_shift_en = 1'b1;
                cfg_sout     = shreg[0];
                shreg_nx     = shreg >> 1;
                bit_cnt_nx   = bit_cnt + 1'b1;
                wbit_cnt_nx  = wbit_cnt + 1'b1;
                // Chain end wins over word end, so unused upper bits of a
                // partial last word are never shifted out.
                if (bit_cnt == LAST_BIT) begin
                    state_nx = DONE;
                end else if (wbit_cnt == LAST_WBIT) begin
                    state_nx = LOAD;
                end
            end

            DONE: begin
                done        = 1'b1;
                bit_cnt_nx  = '0;
                wbit_cnt_nx = '0;
                state_nx    = IDLE;
            end

            default: begin
                state_nx = IDLE;
            end
        endcase

        // Abort overrides everything; a word offered in the same cycle is
        // dropped by keeping the shift register unchanged.
        if (abort) begin
            state_nx    = IDLE;
            shreg_nx    = shreg;
            bit_cnt_nx  = '0;
            wbit_cnt_nx = '0;
        end
    end

endmodule
